// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Holds no logic, so latency and backpressure do not apply.
package mem_bus_arbiter_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT_I = 2'b01,
        ARB_GRANT_D = 2'b10
    } arb_state_t;

    // Command presented to the shared slave by the current owner.
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Counts grant cycles without a slave ack and flags the final allowed cycle.
// expired is combinational from the count; the counter never stalls anything.
// Cleared while idle, so every grant starts from zero.
module arb_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one bus slave between instruction fetch (I) and load/store (D), D first with a starvation cap.
// Grant one cycle after request seen in IDLE; ack passes through combinationally, one IDLE cycle between transfers.
// Waiting masters are held by stallreq_if/stallreq_mem; a silent slave is cut off by a timeout error completion.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t  state;
    logic [SW-1:0] streak;
    logic        expired;
    logic        streak_full;
    logic        grant_i;
    logic        grant_d;
    bus_cmd_t    m_cmd;

    assign streak_full = (streak == SW'(MAX_D_STREAK));

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state  <= ARB_IDLE;
            streak <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // D wins unless I has waited through a full streak of D grants.
                    if (d_req && !(i_req && streak_full)) begin
                        state  <= ARB_GRANT_D;
                        streak <= i_req ? streak + 1'b1 : '0;
                    end else if (i_req) begin
                        state  <= ARB_GRANT_I;
                        streak <= '0;
                    end
                end
                ARB_GRANT_I, ARB_GRANT_D: begin
                    if (m_ack || expired) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ARB_IDLE),
        .en      ((state != ARB_IDLE) && !m_ack),
        .expired (expired)
    );

    always_comb begin
        m_cmd = '0;
        case (state)
            ARB_GRANT_I: begin
                m_cmd.addr = i_addr;
                m_cmd.sel  = 4'hF;
            end
            ARB_GRANT_D: begin
                m_cmd.we    = d_we;
                m_cmd.sel   = d_sel;
                m_cmd.addr  = d_addr;
                m_cmd.wdata = d_wdata;
            end
            default: m_cmd = '0;
        endcase
    end

    assign m_req   = (state != ARB_IDLE);
    assign m_we    = m_cmd.we;
    assign m_sel   = m_cmd.sel;
    assign m_addr  = m_cmd.addr;
    assign m_wdata = m_cmd.wdata;

    // A grant being torn down by reset must not complete toward its master.
    assign grant_i = (state == ARB_GRANT_I) && (rst != RST_ENABLE);
    assign grant_d = (state == ARB_GRANT_D) && (rst != RST_ENABLE);

    assign i_ack   = grant_i && (m_ack || expired);
    assign i_err   = grant_i && expired && !m_ack;
    assign i_rdata = (grant_i && m_ack) ? m_rdata : ZERO_WORD;

    assign d_ack   = grant_d && (m_ack || expired);
    assign d_err   = grant_d && expired && !m_ack;
    assign d_rdata = (grant_d && m_ack) ? m_rdata : ZERO_WORD;

    assign stallreq_if  = i_req && !i_ack;
    assign stallreq_mem = d_req && !d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven and outputs sampled just after each falling edge.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stallreq_if;
    logic        stallreq_mem;

    int n_checks = 0;
    int n_fails  = 0;

    mem_bus_arbiter #(
        .MAX_D_STREAK (4),
        .TIMEOUT      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_ack        (i_ack),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_sel        (d_sel),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .d_err        (d_err),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_sel        (m_sel),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .m_ack        (m_ack),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; the rising edge in between commits the previous cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    int          acks_seen;
    logic [19:0] exp_d_pat;
    logic [19:0] exp_i_pat;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ack = 1'b0;

        // Reset state, with requests present to show they are ignored.
        next_cycle(); i_req = 1'b1; d_req = 1'b1; d_addr = 32'h44; settle();
        check("rst_m_req",  32'(m_req), 32'd0);
        check("rst_acks",   {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        next_cycle(); settle();
        check("rst_m_req2", 32'(m_req), 32'd0);
        check("rst_rdata",  i_rdata | d_rdata, 32'd0);
        i_req = 1'b0; d_req = 1'b0; d_addr = '0;

        // 1: single fetch, slave acks one cycle after m_req.
        next_cycle(); rst = 1'b0; i_req = 1'b1; i_addr = 32'h100; settle();
        check("t1_c0_m_req",  32'(m_req), 32'd0);
        check("t1_c0_stall",  32'(stallreq_if), 32'd1);
        next_cycle(); settle();
        check("t1_c1_m_req",  32'(m_req), 32'd1);
        check("t1_c1_m_addr", m_addr, 32'h100);
        check("t1_c1_m_we",   32'(m_we), 32'd0);
        check("t1_c1_stall",  32'(stallreq_if), 32'd1);
        check("t1_c1_i_ack",  32'(i_ack), 32'd0);
        next_cycle(); m_ack = 1'b1; m_rdata = 32'h3402_0001; settle();
        check("t1_c2_i_ack",   32'(i_ack), 32'd1);
        check("t1_c2_i_rdata", i_rdata, 32'h3402_0001);
        check("t1_c2_i_err",   32'(i_err), 32'd0);
        check("t1_c2_d_ack",   32'(d_ack), 32'd0);
        check("t1_c2_stall",   32'(stallreq_if), 32'd0);
        next_cycle(); i_req = 1'b0; m_ack = 1'b0; settle();
        check("t1_c3_m_req",  32'(m_req), 32'd0);
        check("t1_c3_m_addr", m_addr, 32'd0);

        // 2: simultaneous requests, D store goes first.
        next_cycle(); i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; settle();
        check("t2_c0_stall_mem", 32'(stallreq_mem), 32'd1);
        next_cycle(); m_ack = 1'b1; m_rdata = 32'h5555_AAAA; settle();
        check("t2_c1_m_we",    32'(m_we), 32'd1);
        check("t2_c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check("t2_c1_m_addr",  m_addr, 32'h200);
        check("t2_c1_m_sel",   32'(m_sel), 32'hF);
        check("t2_c1_acks",    {30'd0, i_ack, d_ack}, 32'd1);
        check("t2_c1_stall_if", 32'(stallreq_if), 32'd1);
        next_cycle(); m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_wdata = '0; settle();
        check("t2_c2_m_req", 32'(m_req), 32'd0);
        next_cycle(); m_ack = 1'b1; m_rdata = 32'h0000_1234; settle();
        check("t2_c3_m_addr", m_addr, 32'h104);
        check("t2_c3_m_we",   32'(m_we), 32'd0);
        check("t2_c3_acks",   {30'd0, i_ack, d_ack}, 32'd2);
        check("t2_c3_rdata",  i_rdata, 32'h0000_1234);
        next_cycle(); m_ack = 1'b0; i_req = 1'b0; settle();

        // 3: both held, slave acks at once; D gets 4, then I, then D again for 4.
        exp_d_pat = 20'h2A8AA;
        exp_i_pat = 20'h80200;
        i_req = 1'b1; i_addr = 32'h108; d_req = 1'b1; d_addr = 32'h400;
        for (int k = 0; k < 20; k++) begin
            if (k != 0) next_cycle();
            m_ack = 1'b0; settle();
            m_ack = m_req; m_rdata = 32'(k); settle();
            check($sformatf("t3_d_ack_%0d", k), 32'(d_ack), 32'(exp_d_pat[k]));
            check($sformatf("t3_i_ack_%0d", k), 32'(i_ack), 32'(exp_i_pat[k]));
        end
        next_cycle(); i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; d_addr = '0; settle();

        // 4: D load, slave silent -> timeout error, late ack ignored.
        next_cycle(); d_req = 1'b1; d_addr = 32'h300; m_rdata = 32'hFFFF_FFFF; settle();
        acks_seen = 0;
        for (int k = 1; k < 16; k++) begin
            next_cycle(); settle();
            acks_seen += int'(d_ack) + int'(i_ack);
        end
        check("t4_early_acks", 32'(acks_seen), 32'd0);
        check("t4_m_req_pre", 32'(m_req), 32'd1);
        next_cycle(); settle();
        check("t4_d_ack",   32'(d_ack), 32'd1);
        check("t4_d_err",   32'(d_err), 32'd1);
        check("t4_d_rdata", d_rdata, 32'd0);
        check("t4_m_req",   32'(m_req), 32'd1);
        next_cycle(); d_req = 1'b0; d_addr = '0; settle();
        check("t4_idle_m_req", 32'(m_req), 32'd0);
        next_cycle(); m_ack = 1'b1; settle();
        check("t4_late_acks", {30'd0, i_ack, d_ack}, 32'd0);
        next_cycle(); m_ack = 1'b0; settle();

        // 5: ack lands on the timeout cycle; ack wins.
        next_cycle(); d_req = 1'b1; d_addr = 32'h304; settle();
        for (int k = 1; k < 16; k++) next_cycle();
        next_cycle(); m_ack = 1'b1; m_rdata = 32'h1234_5678; settle();
        check("t5_d_ack",   32'(d_ack), 32'd1);
        check("t5_d_err",   32'(d_err), 32'd0);
        check("t5_d_rdata", d_rdata, 32'h1234_5678);
        next_cycle(); d_req = 1'b0; m_ack = 1'b0; d_addr = '0; settle();

        // 6: reset during an I grant aborts it; fetch restarts afterwards.
        next_cycle(); i_req = 1'b1; i_addr = 32'h10C; settle();
        next_cycle(); settle();
        check("t6_grant_m_req", 32'(m_req), 32'd1);
        next_cycle(); rst = 1'b1; settle();
        check("t6_rst_i_ack", 32'(i_ack), 32'd0);
        next_cycle(); rst = 1'b0; settle();
        check("t6_post_m_req", 32'(m_req), 32'd0);
        check("t6_post_i_ack", 32'(i_ack), 32'd0);
        next_cycle(); m_ack = 1'b1; m_rdata = 32'hCAFE_0001; settle();
        check("t6_re_m_addr", m_addr, 32'h10C);
        check("t6_re_i_ack",  32'(i_ack), 32'd1);
        check("t6_re_rdata",  i_rdata, 32'hCAFE_0001);
        check("t6_re_i_err",  32'(i_err), 32'd0);
        next_cycle(); i_req = 1'b0; m_ack = 1'b0; settle();
        check("t6_end_m_req", 32'(m_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
